trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 63 ++++++
 rtl/trap_prio_enc.sv | 93 +++++++++
 rtl/trap_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared cause codes, CSR addresses, FSM state encodings and
//                mstatus update helpers for the trap controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_pkg;

  // Machine-mode CSR addresses touched by the trap sequence
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  // Exception cause codes (mcause[31] = 0)
  localparam logic [4:0] CAUSE_INS_ADDR_MIS   = 5'd0;
  localparam logic [4:0] CAUSE_INS_ACC_FAULT  = 5'd1;
  localparam logic [4:0] CAUSE_ILL_INS        = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK         = 5'd3;
  localparam logic [4:0] CAUSE_LD_ADDR_MIS    = 5'd4;
  localparam logic [4:0] CAUSE_LD_ACC_FAULT   = 5'd5;
  localparam logic [4:0] CAUSE_ST_ADDR_MIS    = 5'd6;
  localparam logic [4:0] CAUSE_ST_ACC_FAULT   = 5'd7;
  localparam logic [4:0] CAUSE_ECALL          = 5'd11;
  localparam logic [4:0] CAUSE_INS_PAGE_FAULT = 5'd12;
  localparam logic [4:0] CAUSE_LD_PAGE_FAULT  = 5'd13;
  localparam logic [4:0] CAUSE_ST_PAGE_FAULT  = 5'd15;

  // FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_W_EPC    = 3'd1;
  localparam state_t ST_W_CAUSE  = 3'd2;
  localparam state_t ST_W_TVAL   = 3'd3;
  localparam state_t ST_W_STATUS = 3'd4;
  localparam state_t ST_REDIRECT = 3'd5;
  localparam state_t ST_M_STATUS = 3'd6;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= machine
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r          = s;
    r[7]       = s[3];
    r[3]       = 1'b0;
    r[12:11]   = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP <= user
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r          = s;
    r[3]       = s[7];
    r[7]       = 1'b1;
    r[12:11]   = 2'b00;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_prio_enc.sv
// ============================================================================
//  Module      : trap_prio_enc
//  Description : Combinational priority selection of the winning trap source,
//                producing mcause and the trap value for the current
//                instruction. Interrupts beat exceptions, exceptions beat mret.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_prio_enc
  import trap_pkg::*;
#(
  parameter int IRQ_CAUSE = 11
) (
  input  logic        int_acc,
  input  logic        ill_ins,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        ins_addr_mis,
  input  logic        ins_acc_fault,
  input  logic        ins_page_fault,
  input  logic        ld_addr_mis,
  input  logic        st_addr_mis,
  input  logic        ld_acc_fault,
  input  logic        st_acc_fault,
  input  logic        ld_page_fault,
  input  logic        st_page_fault,
  input  logic        m_ret,
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [31:0] bad_addr,
  output logic        take,
  output logic        is_irq,
  output logic        is_mret,
  output logic [31:0] cause,
  output logic [31:0] tval
);

  // Fixed-priority select of cause code and trap value
  always_comb begin
    take    = 1'b1;
    is_irq  = 1'b0;
    is_mret = 1'b0;
    cause   = 32'd0;
    tval    = 32'd0;
    if (int_acc) begin
      is_irq = 1'b1;
      cause  = {1'b1, 31'(IRQ_CAUSE)};
    end else if (ins_page_fault) begin
      cause = {27'd0, CAUSE_INS_PAGE_FAULT};
      tval  = bad_addr;
    end else if (ins_acc_fault) begin
      cause = {27'd0, CAUSE_INS_ACC_FAULT};
      tval  = bad_addr;
    end else if (ill_ins) begin
      cause = {27'd0, CAUSE_ILL_INS};
      tval  = ins;
    end else if (ins_addr_mis) begin
      cause = {27'd0, CAUSE_INS_ADDR_MIS};
      tval  = bad_addr;
    end else if (ecall) begin
      cause = {27'd0, CAUSE_ECALL};
    end else if (ebreak) begin
      cause = {27'd0, CAUSE_EBREAK};
      tval  = pc;
    end else if (st_addr_mis) begin
      cause = {27'd0, CAUSE_ST_ADDR_MIS};
      tval  = bad_addr;
    end else if (ld_addr_mis) begin
      cause = {27'd0, CAUSE_LD_ADDR_MIS};
      tval  = bad_addr;
    end else if (st_page_fault) begin
      cause = {27'd0, CAUSE_ST_PAGE_FAULT};
      tval  = bad_addr;
    end else if (ld_page_fault) begin
      cause = {27'd0, CAUSE_LD_PAGE_FAULT};
      tval  = bad_addr;
    end else if (st_acc_fault) begin
      cause = {27'd0, CAUSE_ST_ACC_FAULT};
      tval  = bad_addr;
    end else if (ld_acc_fault) begin
      cause = {27'd0, CAUSE_LD_ACC_FAULT};
      tval  = bad_addr;
    end else if (m_ret) begin
      is_mret = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap sequencer. Captures the winning trap source
//                of a valid instruction, writes mepc/mcause/(mtval)/mstatus one
//                CSR per cycle, then redirects the PC to the trap vector. mret
//                restores mstatus and redirects to mepc.
//                Build option: TRAP_CTRL_TVAL_EN adds the mtval write state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl
  import trap_pkg::*;
#(
  parameter int IRQ_CAUSE = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        ill_ins,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        ins_addr_mis,
  input  logic        ins_acc_fault,
  input  logic        ins_page_fault,
  input  logic        ld_addr_mis,
  input  logic        st_addr_mis,
  input  logic        ld_acc_fault,
  input  logic        st_acc_fault,
  input  logic        ld_page_fault,
  input  logic        st_page_fault,
  input  logic        int_acc,
  input  logic        m_ret,
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [31:0] bad_addr,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_write,
  output logic [11:0] csr_write_index,
  output logic [31:0] csr_data_w,
  output logic        trap_stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        trap_busy
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic        r_irq;
  logic        r_mret;

  logic        w_take;
  logic        w_is_irq;
  logic        w_is_mret;
  logic [31:0] w_cause;
  logic [31:0] w_tval;
  logic        w_capture;
  logic [31:0] w_vector;

  trap_prio_enc #(
    .IRQ_CAUSE (IRQ_CAUSE)
  ) u_prio (
    .int_acc        (int_acc),
    .ill_ins        (ill_ins),
    .ecall          (ecall),
    .ebreak         (ebreak),
    .ins_addr_mis   (ins_addr_mis),
    .ins_acc_fault  (ins_acc_fault),
    .ins_page_fault (ins_page_fault),
    .ld_addr_mis    (ld_addr_mis),
    .st_addr_mis    (st_addr_mis),
    .ld_acc_fault   (ld_acc_fault),
    .st_acc_fault   (st_acc_fault),
    .ld_page_fault  (ld_page_fault),
    .st_page_fault  (st_page_fault),
    .m_ret          (m_ret),
    .pc             (pc),
    .ins            (ins),
    .bad_addr       (bad_addr),
    .take           (w_take),
    .is_irq         (w_is_irq),
    .is_mret        (w_is_mret),
    .cause          (w_cause),
    .tval           (w_tval)
  );

  // Events are only sampled while idle; reset suppresses capture immediately
  assign w_capture = rst && (r_state == ST_IDLE) && valid && w_take;

  // Vectored mode only offsets interrupts; exceptions always use the base
  assign w_vector = {mtvec_i[31:2], 2'b00} +
                    ((r_irq && (mtvec_i[1:0] == 2'b01)) ? (32'(IRQ_CAUSE) << 2) : 32'd0);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the trap context on the capture cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc   <= 32'd0;
      r_cause <= 32'd0;
      r_irq   <= 1'b0;
      r_mret  <= 1'b0;
    end else if (w_capture) begin
      r_epc   <= pc;
      r_cause <= w_cause;
      r_irq   <= w_is_irq;
      r_mret  <= w_is_mret;
    end
  end

`ifdef TRAP_CTRL_TVAL_EN
  logic [31:0] r_tval;

  // Trap value is only kept when the mtval write state is built in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tval <= 32'd0;
    end else if (w_capture) begin
      r_tval <= w_tval;
    end
  end
`else
  logic w_unused_tval;
  assign w_unused_tval = ^w_tval;
`endif

  // Next-state: one CSR write per cycle, then a single redirect cycle
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_next = w_capture ? (w_is_mret ? ST_M_STATUS : ST_W_EPC) : ST_IDLE;
      ST_W_EPC:    w_next = ST_W_CAUSE;
`ifdef TRAP_CTRL_TVAL_EN
      ST_W_CAUSE:  w_next = ST_W_TVAL;
`else
      ST_W_CAUSE:  w_next = ST_W_STATUS;
`endif
      ST_W_TVAL:   w_next = ST_W_STATUS;
      ST_W_STATUS: w_next = ST_REDIRECT;
      ST_M_STATUS: w_next = ST_REDIRECT;
      ST_REDIRECT: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Outputs: CSR port, redirect and pipeline control; all zero in reset
  always_comb begin
    csr_write       = 1'b0;
    csr_write_index = 12'd0;
    csr_data_w      = 32'd0;
    pc_redirect     = 1'b0;
    redirect_pc     = 32'd0;
    flush           = 1'b0;
    trap_stall      = 1'b0;
    trap_busy       = 1'b0;
    if (rst) begin
      flush      = w_capture;
      trap_stall = w_capture || (r_state != ST_IDLE);
      trap_busy  = w_capture || (r_state != ST_IDLE);
      case (r_state)
        ST_W_EPC: begin
          csr_write       = 1'b1;
          csr_write_index = CSR_MEPC;
          csr_data_w      = r_epc;
        end
        ST_W_CAUSE: begin
          csr_write       = 1'b1;
          csr_write_index = CSR_MCAUSE;
          csr_data_w      = r_cause;
        end
`ifdef TRAP_CTRL_TVAL_EN
        ST_W_TVAL: begin
          csr_write       = 1'b1;
          csr_write_index = CSR_MTVAL;
          csr_data_w      = r_tval;
        end
`endif
        ST_W_STATUS: begin
          csr_write       = 1'b1;
          csr_write_index = CSR_MSTATUS;
          csr_data_w      = mstatus_on_trap(mstatus_i);
        end
        ST_M_STATUS: begin
          csr_write       = 1'b1;
          csr_write_index = CSR_MSTATUS;
          csr_data_w      = mstatus_on_mret(mstatus_i);
        end
        ST_REDIRECT: begin
          pc_redirect = 1'b1;
          redirect_pc = r_mret ? mepc_i : w_vector;
        end
        default: begin
          csr_write = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Randomised scoreboard bench for trap_ctrl. Stimulus pushes the
//                expected CSR writes and redirect (with cycle stamps) into a
//                queue; a monitor on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trap_ctrl;

  localparam int IRQ_CAUSE = 11;
`ifdef TRAP_CTRL_TVAL_EN
  localparam bit TVAL_EN = 1'b1;
`else
  localparam bit TVAL_EN = 1'b0;
`endif

  // Event vector bit order follows trap priority (0 = highest)
  localparam int B_INT = 0, B_IPF = 1, B_IAF = 2, B_ILL = 3, B_IAM = 4, B_ECALL = 5,
                 B_EBRK = 6, B_SAM = 7, B_LAM = 8, B_SPF = 9, B_LPF = 10, B_SAF = 11,
                 B_LAF = 12, B_MRET = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [13:0] ev;
  logic [31:0] pc, ins, bad_addr, mtvec_i, mepc_i, mstatus_i;
  logic        csr_write;
  logic [11:0] csr_write_index;
  logic [31:0] csr_data_w;
  logic        trap_stall, flush, pc_redirect, trap_busy;
  logic [31:0] redirect_pc;

  trap_ctrl #(.IRQ_CAUSE(IRQ_CAUSE)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid           (valid),
    .ill_ins         (ev[B_ILL]),
    .ecall           (ev[B_ECALL]),
    .ebreak          (ev[B_EBRK]),
    .ins_addr_mis    (ev[B_IAM]),
    .ins_acc_fault   (ev[B_IAF]),
    .ins_page_fault  (ev[B_IPF]),
    .ld_addr_mis     (ev[B_LAM]),
    .st_addr_mis     (ev[B_SAM]),
    .ld_acc_fault    (ev[B_LAF]),
    .st_acc_fault    (ev[B_SAF]),
    .ld_page_fault   (ev[B_LPF]),
    .st_page_fault   (ev[B_SPF]),
    .int_acc         (ev[B_INT]),
    .m_ret           (ev[B_MRET]),
    .pc              (pc),
    .ins             (ins),
    .bad_addr        (bad_addr),
    .mtvec_i         (mtvec_i),
    .mepc_i          (mepc_i),
    .mstatus_i       (mstatus_i),
    .csr_write       (csr_write),
    .csr_write_index (csr_write_index),
    .csr_data_w      (csr_data_w),
    .trap_stall      (trap_stall),
    .flush           (flush),
    .pc_redirect     (pc_redirect),
    .redirect_pc     (redirect_pc),
    .trap_busy       (trap_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          redir;
    logic [11:0] idx;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_flush = 1'b0;
  logic exp_busy = 1'b0;

  // mcause codes indexed by event bit (index 0 is the interrupt, handled apart)
  int cause_tab [13] = '{0, 12, 1, 2, 0, 11, 3, 6, 4, 15, 13, 7, 5};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push(input int cy, input bit r, input logic [11:0] ix, input logic [31:0] d);
    exp_t e;
    e.cyc = cy; e.redir = r; e.idx = ix; e.data = d;
    q.push_back(e);
  endtask

  function automatic int first_set(input logic [13:0] e);
    for (int i = 0; i < 14; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] st_trap(input logic [31:0] s);
    logic [31:0] mie;
    mie = (s >> 3) & 32'd1;
    return (s & ~32'h0000_1888) | (mie << 7) | (32'd3 << 11);
  endfunction

  function automatic logic [31:0] st_mret(input logic [31:0] s);
    logic [31:0] mpie;
    mpie = (s >> 7) & 32'd1;
    return (s & ~32'h0000_1888) | (mpie << 3) | (32'd1 << 7);
  endfunction

  // Issue one instruction slot; if it traps, hold CSR inputs steady for the
  // sequence while driving junk events that must be ignored.
  task automatic run(input logic v, input logic [13:0] e, input logic [31:0] p,
                     input logic [31:0] i, input logic [31:0] b, input logic [31:0] tv,
                     input logic [31:0] ep, input logic [31:0] st,
                     input bit rnd_junk, input logic [13:0] junk, input int rst_at);
    int c, n, len;
    logic [31:0] cause, tval, vec;
    @(posedge clk); #1;
    valid = v; ev = e; pc = p; ins = i; bad_addr = b;
    mtvec_i = tv; mepc_i = ep; mstatus_i = st;
    c = cyc;
    n = v ? first_set(e) : -1;
    len = 0;
    if (n == B_MRET) begin
      push(c + 1, 1'b0, 12'h300, st_mret(st));
      push(c + 2, 1'b1, 12'h000, ep);
      len = 2;
    end else if (n >= 0) begin
      if (n == B_INT) begin
        cause = 32'h8000_0000 + 32'(IRQ_CAUSE);
        tval  = 32'd0;
      end else begin
        cause = 32'(cause_tab[n]);
        tval  = (n == B_ILL) ? i : (n == B_ECALL) ? 32'd0 : (n == B_EBRK) ? p : b;
      end
      vec = tv & ~32'd3;
      if (n == B_INT && tv[1:0] == 2'b01) vec = vec + 32'(4 * IRQ_CAUSE);
      len = TVAL_EN ? 5 : 4;
      push(c + 1, 1'b0, 12'h341, p);
      push(c + 2, 1'b0, 12'h342, cause);
      if (TVAL_EN) push(c + 3, 1'b0, 12'h343, tval);
      push(c + len - 1, 1'b0, 12'h300, st_trap(st));
      push(c + len, 1'b1, 12'h000, vec);
    end
    exp_flush = (len > 0);
    exp_busy  = (len > 0);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      exp_flush = 1'b0;
      valid    = rnd_junk ? 1'($urandom_range(0, 1)) : 1'b1;
      ev       = rnd_junk ? 14'($urandom) : junk;
      pc       = $urandom;
      ins      = $urandom;
      bad_addr = $urandom;
      if (k == rst_at) begin
        rst = 1'b0;
        exp_busy = 1'b0;
        while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
        @(posedge clk); #1;
        valid = 1'b0; ev = '0;
        rst = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: compare DUT outputs against the scoreboard each cycle
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_total++;
      $display("FAIL missing_output: got nothing expected idx %h data %h at cycle %0d", q[0].idx, q[0].data, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      if (e.redir) begin
        chk("pc_redirect", {31'd0, pc_redirect}, 32'd1);
        chk("redirect_pc", redirect_pc, e.data);
        chk("no_write_in_redirect", {31'd0, csr_write}, 32'd0);
      end else begin
        chk("csr_write", {31'd0, csr_write}, 32'd1);
        chk("csr_write_index", {20'd0, csr_write_index}, {20'd0, e.idx});
        chk("csr_data_w", csr_data_w, e.data);
        chk("no_redirect_in_write", {31'd0, pc_redirect}, 32'd0);
      end
    end else begin
      chk("spurious_csr_write", {31'd0, csr_write}, 32'd0);
      chk("spurious_pc_redirect", {31'd0, pc_redirect}, 32'd0);
    end
    if (!csr_write) begin
      chk("idle_index_zero", {20'd0, csr_write_index}, 32'd0);
      chk("idle_data_zero", csr_data_w, 32'd0);
    end
    if (!rst) chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("flush", {31'd0, flush}, {31'd0, exp_flush});
    chk("trap_busy", {31'd0, trap_busy}, {31'd0, exp_busy});
    chk("trap_stall", {31'd0, trap_stall}, {31'd0, exp_busy});
  end

  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [13:0] e;
    rst = 1'b0; valid = 1'b0; ev = '0;
    pc = '0; ins = '0; bad_addr = '0; mtvec_i = '0; mepc_i = '0; mstatus_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Illegal instruction with fixed operands
    run(1'b1, 14'd1 << B_ILL, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h800, 32'h0, 32'h0, 1'b1, '0, 0);
    // Interrupt beats a simultaneous load misalign; vectored mtvec
    run(1'b1, (14'd1 << B_INT) | (14'd1 << B_LAM), 32'h200, 32'h0, 32'h1234, 32'h801, 32'h0, 32'h8, 1'b1, '0, 0);
    // mret
    run(1'b1, 14'd1 << B_MRET, 32'h300, 32'h0, 32'h0, 32'h800, 32'h240, 32'h80, 1'b1, '0, 0);
    // ecall with ebreak presented throughout the sequence
    run(1'b1, 14'd1 << B_ECALL, 32'h400, 32'h0, 32'h0, 32'h800, 32'h0, 32'h0, 1'b0, 14'd1 << B_EBRK, 0);
    // Reset mid-sequence, then a clean ecall
    run(1'b1, 14'd1 << B_ECALL, 32'h500, 32'h0, 32'h0, 32'h800, 32'h0, 32'h8, 1'b1, '0, TVAL_EN ? 3 : 2);
    run(1'b1, 14'd1 << B_ECALL, 32'h504, 32'h0, 32'h0, 32'h800, 32'h0, 32'h8, 1'b1, '0, 0);
    // Store page fault
    run(1'b1, 14'd1 << B_SPF, 32'h600, 32'h0, 32'hDEAD_BEEF, 32'h1000, 32'h0, 32'h1888, 1'b1, '0, 0);
    // Exception over mret
    run(1'b1, (14'd1 << B_MRET) | (14'd1 << B_LAF), 32'h700, 32'h0, 32'hCAFE_0000, 32'h901, 32'h44, 32'h0, 1'b1, '0, 0);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       e = '0;
        1, 2:    e = 14'($urandom);
        default: e = (14'd1 << $urandom_range(0, 13)) | ((14'd1 << $urandom_range(0, 13)) & {14{1'($urandom_range(0, 1))}});
      endcase
      run(($urandom_range(0, 9) != 0), e, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, 1'b1, '0, 0);
    end

    @(posedge clk); #1;
    valid = 1'b0; ev = '0; exp_busy = 1'b0; exp_flush = 1'b0;
    repeat (10) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
